// File: rtl/serial_bit_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_bit_engine_if
// Description : Handshake and data bundle for serial_bit_engine.
//               master : drives start/op/a/b, observes busy/done/result
//               slave  : the engine side
//   start  - request to begin an operation (honoured only when idle)
//   op     - 0 = Hamming distance of a and b, 1 = two's complement of a
//   a, b   - WIDTH-bit operands
//   busy   - high while bits are being processed
//   done   - one-cycle completion pulse
//   result - result of the last completed operation
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_bit_engine_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, op, a, b,
      input  busy, done, result
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result
   );
endinterface
`default_nettype wire

// File: rtl/serial_bit_engine.sv
`default_nettype none
// ============================================================================
// Module      : serial_bit_engine
// Description : Bit-serial engine processing one operand bit per cycle, LSB
//               first, for WIDTH cycles. op=0 counts differing bits of a and
//               b (Hamming distance); op=1 forms the two's complement of a.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               sif   - serial_bit_engine_if slave modport
//                       (start, op, a, b in; busy, done, result out)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_bit_engine #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_bit_engine_if.slave   sif
);

   localparam int             IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q,  state_d;
   logic [IDX_W-1:0] idx_q,    idx_d;
   logic [WIDTH-1:0] a_q,      a_d;
   logic [WIDTH-1:0] b_q,      b_d;
   logic             op_q,     op_d;
   logic             carry_q,  carry_d;
   logic [WIDTH-1:0] work_q,   work_d;
   logic [WIDTH-1:0] result_q, result_d;

   // Per-bit datapath. Operands are shifted right each RUN cycle, so bit 0
   // of the captured registers is always the bit currently being processed.
   logic             diff_bit;
   logic             neg_bit;
   logic             neg_carry;
   logic [WIDTH-1:0] work_next;

   always_comb begin
      diff_bit  = a_q[0] ^ b_q[0];
      neg_bit   = ~a_q[0] ^ carry_q;
      neg_carry = ~a_q[0] & carry_q;

      // work_q doubles as the difference counter (op=0) and as the result
      // being assembled bit by bit at position idx_q (op=1).
      work_next = work_q;
      if (op_q) begin
         work_next[idx_q] = neg_bit;
      end else begin
         work_next = work_q + WIDTH'(diff_bit);
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      carry_d  = carry_q;
      work_d   = work_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            if (sif.start) begin
               a_d     = sif.a;
               b_d     = sif.b;
               op_d    = sif.op;
               idx_d   = '0;
               carry_d = 1'b1;
               work_d  = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = neg_carry;
            work_d  = work_next;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               // Only the completing edge publishes; the final carry-out
               // is simply dropped.
               result_d = work_next;
               idx_d    = '0;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= 1'b0;
         carry_q  <= 1'b0;
         work_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         carry_q  <= carry_d;
         work_q   <= work_d;
         result_q <= result_d;
      end
   end

   // Status decoded straight from the state register so reset clears it
   // without waiting for a clock edge.
   assign sif.busy   = (state_q == S_RUN);
   assign sif.done   = (state_q == S_DONE);
   assign sif.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_bit_engine
// Description : Self-checking bench for serial_bit_engine (WIDTH=8).
//               Directed vector table plus hand-written corner sequences
//               (ignored start, mid-run reset, back-to-back operation) and
//               model-based sweeps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_bit_engine;

   localparam int WIDTH = 8;

   logic clk;
   logic rst_n;

   serial_bit_engine_if #(.WIDTH(WIDTH)) sif ();

   serial_bit_engine #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (sif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc;
   always @(posedge clk) cyc <= cyc + 1;

   int checks;
   int failures;
   logic [WIDTH-1:0] prev_result;

   typedef struct packed {
      logic             op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] exp;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the
   // DUT idle again.
   task automatic run_op(input logic o, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] exp,
                         input string name);
      int  busy_cnt;
      bit  early_done;
      bit  held;
      sif.start = 1'b1;
      sif.op    = o;
      sif.a     = av;
      sif.b     = bv;
      @(negedge clk);
      sif.start = 1'b0;
      busy_cnt   = 0;
      early_done = 0;
      held       = 1;
      for (int c = 1; c <= WIDTH; c++) begin
         if (c > 1) @(negedge clk);
         if (sif.busy === 1'b1) busy_cnt++;
         if (sif.done !== 1'b0) early_done = 1;
         if (sif.result !== prev_result) held = 0;
      end
      @(negedge clk);
      chk({name, " busy_cycles"}, busy_cnt, WIDTH);
      chk({name, " no_early_done"}, {31'd0, early_done}, 32'd0);
      chk({name, " result_held"}, {31'd0, held}, 32'd1);
      chk({name, " done_busy"}, {30'd0, sif.done, sif.busy}, 32'd2);
      chk({name, " result"}, sif.result, exp);
      prev_result = exp;
      @(negedge clk);
      chk({name, " back_idle"}, {30'd0, sif.done, sif.busy}, 32'd0);
   endtask

   initial begin
      int done_cnt;
      int t_done [3];
      int nd;
      logic [WIDTH-1:0] ra, rb;

      checks      = 0;
      failures    = 0;
      cyc         = 0;
      prev_result = '0;
      sif.start   = 1'b0;
      sif.op      = 1'b0;
      sif.a       = '0;
      sif.b       = '0;

      // op, a, b, expected (hand computed)
      vecs[0]  = '{1'b1, 8'h35, 8'h00, 8'hCB};
      vecs[1]  = '{1'b0, 8'hC6, 8'hED, 8'd4};
      vecs[2]  = '{1'b0, 8'hFF, 8'h00, 8'd8};
      vecs[3]  = '{1'b1, 8'h00, 8'h00, 8'h00};
      vecs[4]  = '{1'b1, 8'h80, 8'h00, 8'h80};
      vecs[5]  = '{1'b1, 8'h01, 8'h00, 8'hFF};
      vecs[6]  = '{1'b0, 8'hAA, 8'h55, 8'd8};
      vecs[7]  = '{1'b0, 8'h5A, 8'h5A, 8'd0};
      vecs[8]  = '{1'b1, 8'hFF, 8'h12, 8'h01};
      vecs[9]  = '{1'b1, 8'h7F, 8'h00, 8'h81};
      vecs[10] = '{1'b0, 8'h0F, 8'h01, 8'd3};
      vecs[11] = '{1'b1, 8'h02, 8'hFF, 8'hFE};

      // Reset state
      rst_n = 1'b0;
      #3;
      chk("reset busy", {31'd0, sif.busy}, 32'd0);
      chk("reset done", {31'd0, sif.done}, 32'd0);
      chk("reset result", {24'd0, sif.result}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Idle without start: nothing happens
      for (int i = 0; i < 3; i++) @(negedge clk);
      chk("idle no_start", {22'd0, sif.busy, sif.done, sif.result}, 32'd0);

      // Directed table
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // start re-pulsed and operands changed during RUN are ignored
      sif.start = 1'b1; sif.op = 1'b1; sif.a = 8'h35; sif.b = 8'h00;
      @(negedge clk);
      sif.start = 1'b0;
      done_cnt  = 0;
      for (int c = 1; c <= 2 * (WIDTH + 2); c++) begin
         if (c == 3) begin sif.start = 1'b1; sif.op = 1'b0; sif.a = 8'h01; sif.b = 8'hFF; end
         if (c == 5) sif.start = 1'b0;
         if (sif.done === 1'b1) begin
            done_cnt++;
            chk("ignore_start result", sif.result, 8'hCB);
         end
         if (sif.done === 1'b1 && sif.busy === 1'b1) chk("ignore_start overlap", 32'd1, 32'd0);
         @(negedge clk);
      end
      chk("ignore_start done_count", done_cnt, 1);
      chk("ignore_start final", sif.result, 8'hCB);
      prev_result = 8'hCB;

      // Reset during RUN cycle 4 aborts with no done pulse
      sif.start = 1'b1; sif.op = 1'b0; sif.a = 8'hFF; sif.b = 8'h00;
      @(negedge clk);
      sif.start = 1'b0;
      for (int c = 1; c < 4; c++) @(negedge clk);
      chk("abort pre busy", {31'd0, sif.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort busy", {31'd0, sif.busy}, 32'd0);
      chk("abort done", {31'd0, sif.done}, 32'd0);
      chk("abort result", {24'd0, sif.result}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int c = 0; c < WIDTH + 4; c++) begin
         @(negedge clk);
         if (sif.done === 1'b1) done_cnt++;
      end
      chk("abort no_done", done_cnt, 0);
      chk("abort result_after", {24'd0, sif.result}, 32'd0);
      prev_result = '0;
      run_op(1'b1, 8'h01, 8'h00, 8'hFF, "after_reset");

      // start held high: back-to-back operations every WIDTH+2 cycles
      sif.start = 1'b1; sif.op = 1'b1; sif.a = 8'h35; sif.b = 8'h00;
      nd = 0;
      for (int c = 0; c < 40 && nd < 3; c++) begin
         @(negedge clk);
         if (sif.done === 1'b1) begin
            t_done[nd] = cyc;
            chk($sformatf("b2b result%0d", nd), sif.result, 8'hCB);
            nd++;
         end
      end
      sif.start = 1'b0;
      chk("b2b pulse_count", nd, 3);
      if (nd == 3) begin
         chk("b2b gap1", t_done[1] - t_done[0], WIDTH + 2);
         chk("b2b gap2", t_done[2] - t_done[1], WIDTH + 2);
      end
      // drain whatever is in flight
      for (int c = 0; c < WIDTH + 3; c++) @(negedge clk);
      prev_result = sif.result;
      chk("b2b drained", {30'd0, sif.done, sif.busy}, 32'd0);

      // Model sweeps: every two's complement, plus a sample of Hamming pairs
      for (int i = 0; i < 256; i++) begin
         ra = 8'(i);
         run_op(1'b1, ra, 8'h00, 8'((~ra) + 8'd1), $sformatf("neg%0d", i));
      end
      for (int i = 0; i < 600; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run_op(1'b0, ra, rb, 8'($countones(ra ^ rb)), $sformatf("ham%0h_%0h", ra, rb));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
